rom_load_arbiter: RTL and testbench
===================================

Name: rom_load_arbiter

Overview:
- Owns the single write/read port of the game program/graphics ROM RAM.
- Sequences HPS ROM downloads (ioctl stream) into that RAM and holds the sprint1 core in reset while loading.
- Serves core ROM reads when no download is active.
- Sits between hps_io and the sprint1 core in the emu top; runs on clk_sys.

Parameters:
- ADDR_W, 14, ROM RAM address width (bytes = 2**ADDR_W).
- ROM_INDEX, 8'd0, ioctl_index value that selects this ROM set; other indices are ignored.
- RST_HOLD, 16, clk_sys cycles core_reset_n stays low after load completes or after reset.

Ports:
- clk_sys  in  1  system clock; every flop in the block runs on it.
- Reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download active, from hps_io.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request back to hps_io.
- game_rd  in  1  core read request.
- game_addr  in  ADDR_W  core read address.
- game_data  out  8  read data.
- game_valid  out  1  read data valid.
- mem_addr  out  ADDR_W  RAM address (sync RAM, 1-cycle read latency).
- mem_we  out  1  RAM write enable.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data.
- core_reset_n  out  1  active-low reset to sprint1 core.
- bytes_loaded  out  ADDR_W+1  bytes accepted in the last/current load.
- load_err  out  1  sticky protocol/overrun error.

Behaviour:
- Reset values:
  - ioctl_wait=0, mem_we=0, game_valid=0, game_data=0.
  - core_reset_n=0, bytes_loaded=0, load_err=0.
  - FSM=HOLD with hold counter=0.
- FSM states: HOLD, RUN, LOAD, DRAIN.
- HOLD:
  - core_reset_n=0; counter increments each cycle.
  - When counter==RST_HOLD-1, go to RUN; core_reset_n=1 from the first RUN cycle.
  - A download start (see below) in HOLD goes to LOAD immediately.
- RUN:
  - mem_addr=game_addr (combinational); mem_we=0.
  - game_valid = game_rd registered one cycle; game_data = mem_rdata captured in the same cycle game_valid is high.
  - Rising edge of ioctl_download with ioctl_index==ROM_INDEX: next state LOAD.
  - On entering LOAD: core_reset_n=0 on the next cycle, bytes_loaded cleared to 0, load_err cleared.
- LOAD:
  - game_rd is ignored and game_valid is forced to 0.
  - ioctl_wr captures {ioctl_addr[ADDR_W-1:0], ioctl_dout} into a one-entry pending buffer.
  - Cycle after capture: mem_we=1, mem_addr/mem_wdata from the buffer, buffer clears, bytes_loaded+1.
  - ioctl_wait = pending valid (high exactly during the write cycle).
  - ioctl_wr while the buffer is full: byte dropped, load_err set.
  - ioctl_addr >= 2**ADDR_W: byte dropped without a write or count, load_err set.
  - bytes_loaded saturates at 2**ADDR_W.
  - Falling edge of ioctl_download: go to DRAIN.
- DRAIN:
  - If the buffer is full, perform its write this cycle.
  - Then go to HOLD with counter=0, so the core is released RST_HOLD cycles after the last write.
- Simultaneous ioctl_wr and download falling edge in the same cycle: the byte is captured and written in DRAIN before HOLD.
- Download with ioctl_index != ROM_INDEX: state is unaffected, and the core keeps running.
- Reset asserted mid-LOAD: everything returns to reset values. A partial RAM image is not erased; the core stays in reset through HOLD.
- Edge detection uses a registered copy of ioctl_download, reset to 0.
  - If ioctl_download is already high when Reset_n deasserts, the first sampled cycle counts as a rising edge.

Decomposition:
- Shared package rom_load_pkg holds:
  - FSM state enum (HOLD, RUN, LOAD, DRAIN).
  - ROM index constants for this core.
  - RST_HOLD default.
- One natural sub-module: rom_load_wrbuf, the one-entry pending write buffer with the full flag and overrun detection.
- The FSM, hold counter and read-path mux stay in the top of this block.

Test Plan:
- Reset release with no download: core_reset_n rises at cycle 16 after Reset_n=1; game_rd at addr 0x0123 gives game_valid one cycle later, with game_data equal to the RAM content.
- Index-0 download of 4 bytes (addr 0..3, data A5,5A,FF,00; wr every 3 cycles):
  - four mem_we pulses with matching addr/data;
  - ioctl_wait high 1 cycle after each wr;
  - bytes_loaded=4, load_err=0;
  - core_reset_n low from the cycle after start until 16 cycles after the last write.
- Back-to-back ioctl_wr on consecutive cycles: second byte dropped, load_err=1, bytes_loaded=1.
- Write to ioctl_addr=0x4000 (ADDR_W=14): no mem_we, load_err=1, count unchanged.
- Download with ioctl_index=1 during RUN: core_reset_n stays 1, no mem_we, game reads continue with 1-cycle latency.
- Reset_n pulsed low after 2 of 4 bytes: outputs return to reset values, FSM goes to HOLD, core_reset_n=1 exactly 16 cycles after release.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download arbiter.
// Used by the top-level arbiter and its pending-write buffer.
package rom_load_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2,
        DRAIN = 2'd3
    } load_state_t;

    localparam logic [7:0] ROM_INDEX_GAME   = 8'd0;
    localparam int         RST_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rom_load_wrbuf.sv
// One-entry pending write buffer for ioctl bytes, with overrun and range detection.
// The owner always retires a full entry on the following cycle.
module rom_load_wrbuf #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_sys,
    input  logic              Reset_n,
    input  logic              wr_strobe,
    input  logic [24:0]       wr_addr,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic              overrun,
    output logic              range_err
);

    logic in_range;
    logic accept;

    assign in_range  = (wr_addr[24:ADDR_W] == '0);
    assign overrun   = wr_strobe && full;
    assign range_err = wr_strobe && !in_range;
    assign accept    = wr_strobe && !full && in_range;

    // Full never lasts more than one cycle because the entry is written out immediately.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            full <= accept;
            if (accept) begin
                buf_addr <= wr_addr[ADDR_W-1:0];
                buf_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/rom_load_arbiter.sv
// Owns the ROM RAM port: loads HPS ioctl downloads, holds the core in reset
// while loading, and serves core reads otherwise.
module rom_load_arbiter
    import rom_load_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] ROM_INDEX = ROM_INDEX_GAME,
    parameter int         RST_HOLD  = RST_HOLD_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              Reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic              game_rd,
    input  logic [ADDR_W-1:0] game_addr,
    output logic [7:0]        game_data,
    output logic              game_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              core_reset_n,
    output logic [ADDR_W:0]   bytes_loaded,
    output logic              load_err
);

    localparam int             CNT_W      = $clog2(RST_HOLD + 1);
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    load_state_t       state;
    load_state_t       next_state;
    logic [CNT_W-1:0]  hold_cnt;
    logic              dl_q;
    logic              dl_rise;
    logic              dl_fall;
    logic              valid_q;
    logic [7:0]        data_q;
    logic              full;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              overrun;
    logic              range_err;

    rom_load_wrbuf #(.ADDR_W(ADDR_W)) u_wrbuf (
        .clk_sys   (clk_sys),
        .Reset_n   (Reset_n),
        .wr_strobe (ioctl_wr && (state == LOAD)),
        .wr_addr   (ioctl_addr),
        .wr_data   (ioctl_dout),
        .full      (full),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .overrun   (overrun),
        .range_err (range_err)
    );

    assign dl_rise = ioctl_download && !dl_q && (ioctl_index == ROM_INDEX);
    assign dl_fall = !ioctl_download && dl_q;

    assign ioctl_wait = full;
    assign mem_we     = full;
    assign mem_wdata  = buf_data;
    assign mem_addr   = full ? buf_addr : game_addr;
    assign game_valid = valid_q && (state == RUN);
    assign game_data  = game_valid ? mem_rdata : data_q;

    always_comb begin
        next_state = state;
        case (state)
            HOLD: begin
                if (dl_rise)
                    next_state = LOAD;
                else if (hold_cnt == CNT_W'(RST_HOLD - 1))
                    next_state = RUN;
            end
            RUN:     if (dl_rise) next_state = LOAD;
            LOAD:    if (dl_fall) next_state = DRAIN;
            DRAIN:   next_state = HOLD;
            default: next_state = HOLD;
        endcase
    end

    // Leaving DRAIN restarts the hold counter so the core is released a full hold after the last write.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= HOLD;
            hold_cnt     <= '0;
            dl_q         <= 1'b0;
            core_reset_n <= 1'b0;
            bytes_loaded <= '0;
            load_err     <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state        <= next_state;
            dl_q         <= ioctl_download;
            core_reset_n <= (next_state == RUN);
            hold_cnt     <= (state == HOLD && next_state == HOLD) ? hold_cnt + CNT_W'(1) : '0;
            valid_q      <= game_rd && (state == RUN);
            if (game_valid)
                data_q <= mem_rdata;
            if (state != LOAD && next_state == LOAD) begin
                bytes_loaded <= '0;
                load_err     <= 1'b0;
            end else begin
                if (full && bytes_loaded != FULL_COUNT)
                    bytes_loaded <= bytes_loaded + 1'b1;
                if (overrun || range_err)
                    load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a sync RAM model and
// write/read scoreboards fed by the stimulus.
module tb_rom_load_arbiter;

    logic        clk_sys = 1'b0;
    logic        Reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        game_rd;
    logic [13:0] game_addr;
    logic [7:0]  game_data;
    logic        game_valid;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        core_reset_n;
    logic [14:0] bytes_loaded;
    logic        load_err;

    logic        preload_en;
    logic [13:0] preload_addr;
    logic [7:0]  preload_data;
    logic [7:0]  ram [0:16383];

    int          checks = 0;
    int          errors = 0;
    logic [21:0] wr_queue [$];
    logic [7:0]  rd_queue [$];

    always #5 clk_sys = ~clk_sys;

    rom_load_arbiter dut (
        .clk_sys        (clk_sys),
        .Reset_n        (Reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .game_rd        (game_rd),
        .game_addr      (game_addr),
        .game_data      (game_data),
        .game_valid     (game_valid),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .core_reset_n   (core_reset_n),
        .bytes_loaded   (bytes_loaded),
        .load_err       (load_err)
    );

    // Synchronous RAM, one-cycle read latency, with a bench-side preload port.
    always @(posedge clk_sys) begin
        if (preload_en)
            ram[preload_addr] <= preload_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Scoreboard monitors: every RAM write and every read return is popped and compared.
    always @(negedge clk_sys) begin
        if (Reset_n && mem_we) begin
            check_output("write_expected", 32'(wr_queue.size() > 0), 32'd1);
            if (wr_queue.size() > 0) begin
                logic [21:0] w;
                w = wr_queue.pop_front();
                check_output("write_addr", 32'(mem_addr), 32'(w[21:8]));
                check_output("write_data", 32'(mem_wdata), 32'(w[7:0]));
            end
        end
        if (Reset_n && game_valid) begin
            check_output("read_expected", 32'(rd_queue.size() > 0), 32'd1);
            if (rd_queue.size() > 0)
                check_output("read_data", 32'(game_data), 32'(rd_queue.pop_front()));
        end
    end

    task automatic write_byte(input logic [13:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        wr_queue.push_back({a, d});
        tick(1);
        check_output("wait_on_write", 32'(ioctl_wait), 32'd1);
        check_output("we_on_write", 32'(mem_we), 32'd1);
        check_output("wr_addr_direct", 32'(mem_addr), 32'(a));
        check_output("wr_data_direct", 32'(mem_wdata), 32'(d));
        ioctl_wr = 1'b0;
        tick(1);
        check_output("wait_after_write", 32'(ioctl_wait), 32'd0);
        tick(1);
    endtask

    task automatic read_byte(input logic [13:0] a, input logic [7:0] expected);
        game_rd   = 1'b1;
        game_addr = a;
        rd_queue.push_back(expected);
        #1;
        check_output("read_mem_addr", 32'(mem_addr), 32'(a));
        tick(1);
        check_output("read_valid", 32'(game_valid), 32'd1);
        check_output("read_data_direct", 32'(game_data), 32'(expected));
        game_rd = 1'b0;
        tick(1);
        check_output("read_valid_clear", 32'(game_valid), 32'd0);
        check_output("read_data_held", 32'(game_data), 32'(expected));
    endtask

    task automatic check_release(input string tag);
        tick(15);
        check_output({tag, "_still_held"}, 32'(core_reset_n), 32'd0);
        tick(1);
        check_output({tag, "_released"}, 32'(core_reset_n), 32'd1);
    endtask

    initial begin
        Reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        game_rd        = 1'b0;
        game_addr      = '0;
        preload_en     = 1'b1;
        preload_addr   = 14'h0123;
        preload_data   = 8'h3C;
        tick(2);
        preload_en = 1'b0;
        check_output("rst_wait", 32'(ioctl_wait), 32'd0);
        check_output("rst_we", 32'(mem_we), 32'd0);
        check_output("rst_valid", 32'(game_valid), 32'd0);
        check_output("rst_data", 32'(game_data), 32'd0);
        check_output("rst_core", 32'(core_reset_n), 32'd0);
        check_output("rst_bytes", 32'(bytes_loaded), 32'd0);
        check_output("rst_err", 32'(load_err), 32'd0);

        Reset_n = 1'b1;
        check_release("power_on");
        read_byte(14'h0123, 8'h3C);

        // Normal four-byte download, one write every three cycles.
        ioctl_download = 1'b1;
        tick(1);
        check_output("load_core_held", 32'(core_reset_n), 32'd0);
        write_byte(14'd0, 8'hA5);
        write_byte(14'd1, 8'h5A);
        write_byte(14'd2, 8'hFF);
        write_byte(14'd3, 8'h00);
        check_output("load_core_during", 32'(core_reset_n), 32'd0);
        ioctl_download = 1'b0;
        tick(2);
        check_output("load4_bytes", 32'(bytes_loaded), 32'd4);
        check_output("load4_err", 32'(load_err), 32'd0);
        check_release("after_load4");
        read_byte(14'd2, 8'hFF);
        read_byte(14'd0, 8'hA5);

        // Overrun, out-of-range address, then a write coinciding with the download end.
        ioctl_download = 1'b1;
        tick(1);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd5;
        ioctl_dout = 8'h11;
        wr_queue.push_back({14'd5, 8'h11});
        tick(1);
        ioctl_addr = 25'd6;
        ioctl_dout = 8'h22;
        tick(1);
        ioctl_wr = 1'b0;
        check_output("overrun_err", 32'(load_err), 32'd1);
        check_output("overrun_bytes", 32'(bytes_loaded), 32'd1);
        check_output("overrun_wait", 32'(ioctl_wait), 32'd0);
        tick(1);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h4000;
        ioctl_dout = 8'h77;
        tick(1);
        ioctl_wr = 1'b0;
        check_output("range_no_we", 32'(mem_we), 32'd0);
        tick(1);
        check_output("range_err", 32'(load_err), 32'd1);
        check_output("range_bytes", 32'(bytes_loaded), 32'd1);
        ioctl_wr       = 1'b1;
        ioctl_addr     = 25'd7;
        ioctl_dout     = 8'h33;
        ioctl_download = 1'b0;
        wr_queue.push_back({14'd7, 8'h33});
        tick(1);
        ioctl_wr = 1'b0;
        check_output("drain_we", 32'(mem_we), 32'd1);
        check_output("drain_addr", 32'(mem_addr), 32'd7);
        tick(1);
        check_output("drain_bytes", 32'(bytes_loaded), 32'd2);
        check_release("after_drain");

        // A download for another index must not disturb the running core.
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick(1);
        check_output("other_idx_core", 32'(core_reset_n), 32'd1);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd9;
        ioctl_dout = 8'hEE;
        tick(1);
        ioctl_wr = 1'b0;
        check_output("other_idx_wait", 32'(ioctl_wait), 32'd0);
        check_output("other_idx_we", 32'(mem_we), 32'd0);
        read_byte(14'd5, 8'h11);
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        tick(1);
        check_output("other_idx_core_end", 32'(core_reset_n), 32'd1);
        read_byte(14'd7, 8'h33);

        // Reset in the middle of a load keeps the partial image.
        ioctl_download = 1'b1;
        tick(1);
        check_output("reload_err_clear", 32'(load_err), 32'd0);
        check_output("reload_bytes_clear", 32'(bytes_loaded), 32'd0);
        write_byte(14'd8, 8'h44);
        write_byte(14'd9, 8'h55);
        check_output("partial_bytes", 32'(bytes_loaded), 32'd2);
        Reset_n        = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check_output("midrst_core", 32'(core_reset_n), 32'd0);
        check_output("midrst_bytes", 32'(bytes_loaded), 32'd0);
        check_output("midrst_err", 32'(load_err), 32'd0);
        check_output("midrst_wait", 32'(ioctl_wait), 32'd0);
        tick(2);
        Reset_n = 1'b1;
        check_release("after_midrst");
        read_byte(14'd9, 8'h55);
        read_byte(14'd8, 8'h44);

        tick(2);
        check_output("writes_drained", 32'(wr_queue.size()), 32'd0);
        check_output("reads_drained", 32'(rd_queue.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
